serial2parallel_framed: RTL
===========================

Name: serial2parallel_framed

Overview:
- Parametrised successor to the basic serial-to-parallel shifter.
- Collects a serial bit stream into WIDTH-bit words, with selectable bit order, valid/ready handshakes on both sides, and frame termination.
- A final partial word is zero-padded and tagged with its valid-bit count.
- Sits between bit-serial convolutional encoder/decoder stages and word-oriented consumers (interleaver, packer, output FIFO).

Parameters:
- WIDTH, 2, output word width in bits; legal range 2..64.
- MSB_FIRST, 1, 1: first received bit of a word lands in out_data[WIDTH-1]; 0: first bit lands in out_data[0].
- CNT_W, $clog2(WIDTH+1), width of out_nbits; derived, not overridden.

Ports:
- clk_sig  in  1  single clock, rising edge
- reset_sig  in  1  synchronous, active-high reset
- in_valid  in  1  serial_sig carries a bit this cycle
- in_ready  out  1  block accepts the bit this cycle
- serial_sig  in  1  serial data bit
- in_last  in  1  qualifies the current bit as the final bit of a frame
- out_valid  out  1  out_data/out_nbits/out_last hold a word
- out_ready  in  1  consumer takes the word this cycle
- out_data  out  WIDTH  assembled word
- out_nbits  out  CNT_W  number of valid bits in out_data (1..WIDTH)
- out_last  out  1  word is the final word of a frame

Behaviour:
- Reset (reset_sig=1 at a rising edge; dominates all other inputs):
  - bit counter cnt=0, assembly register=0;
  - out_valid=0, out_data=0, out_nbits=0, out_last=0;
  - any partial word is discarded.
- Handshakes:
  - in_ready = !out_valid || out_ready. It is combinational from state and out_ready only, never from in_valid or in_last.
  - A bit is accepted iff in_valid && in_ready at the rising edge. When not accepted, the bit is not consumed and the source holds it.
  - A word is consumed iff out_valid && out_ready at the rising edge. The output registers are stable while out_valid=1 and out_ready=0.
- Bit placement:
  - An accepted bit is written to index MSB_FIRST ? WIDTH-1-cnt : cnt. Other bits are unchanged.
  - The assembly register is cleared whenever a word is emitted, so unused positions are 0.
- Word completion: an accepted bit with cnt==WIDTH-1 or in_last=1 completes a word. On the same edge:
  - out_data = assembly register including the new bit;
  - out_nbits = cnt+1; out_last = in_last; out_valid=1;
  - cnt=0 and the assembly register is cleared.
  - Otherwise cnt increments.
- Latency: the word is visible one cycle after the edge that accepts its last bit.
- Throughput: with out_ready held at 1, one bit is accepted every cycle with no bubbles, including back-to-back words.
- Partial padding:
  - MSB_FIRST=1: k bits occupy [WIDTH-1:WIDTH-k], lower bits are 0.
  - MSB_FIRST=0: k bits occupy [k-1:0], upper bits are 0.
- Simultaneous events:
  - Drain and completion on the same edge: new word loads and out_valid stays 1.
  - Drain without completion: out_valid falls to 0; out_data/out_nbits/out_last keep their values.
- in_last on a bit with cnt==WIDTH-1: a full word is emitted with out_nbits=WIDTH and out_last=1.
- in_last with in_valid=0, or while in_ready=0: ignored.
- Back-to-back frames need no idle cycle; cnt restarts at 0 after in_last.
- Counter wrap: cnt never exceeds WIDTH-1. No overflow is possible, because backpressure stalls input while the output slot is full.
- Reset mid-word or with out_valid=1: all state is cleared on that edge, and the held word is lost.

Test Plan:
- WIDTH=4, MSB_FIRST=1, out_ready=1, stream 1,0,1,1 then 0,1,1,0 continuously -> out_data=4'hB then 4'h6, each out_valid for 1 cycle, one cycle after its 4th bit; in_ready stays 1.
- WIDTH=4, MSB_FIRST=0, bits 1,0,1,1 -> out_data=4'hD, out_nbits=4, out_last=0.
- WIDTH=8, MSB_FIRST=1, bits 1,1,1 with in_last on third -> out_data=8'hE0, out_nbits=3, out_last=1. Repeat with MSB_FIRST=0 -> 8'h07.
- WIDTH=4, out_ready=0 after first word completes, keep driving bits -> in_ready=0, out_data holds 4'hB stable. Raise out_ready for 1 cycle -> word drained, next bits accepted with no loss or duplication.
- WIDTH=4, 2 bits accepted, then reset_sig=1 for 1 cycle, then bits 0,0,0,1 -> out_data=4'h1, with no residue from the discarded partial word; all outputs are 0 on the cycle after reset.
- WIDTH=2, in_last on 2nd bit of a word, next frame starts the very next cycle -> out_nbits=2, out_last=1, then the next word has out_last=0 and correct data.

Source files
------------

// File: rtl/serial2parallel_framed_if.sv
// Handshake bundle for serial2parallel_framed: bit-serial input side and word output side.
// The slave modport is the converter's view; master is the surrounding source/consumer.
interface serial2parallel_framed_if #(
   parameter int unsigned WIDTH = 2
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic             serial_sig;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] out_nbits;
   logic             out_last;

   modport master (
      output in_valid, serial_sig, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_nbits, out_last
   );

   modport slave (
      input  in_valid, serial_sig, in_last, out_ready,
      output in_ready, out_valid, out_data, out_nbits, out_last
   );
endinterface

// File: rtl/serial2parallel_framed.sv
// Collects a serial bit stream into WIDTH-bit words with selectable bit order and framing.
// A short final word is zero-padded and tagged with its valid-bit count.
module serial2parallel_framed #(
   parameter int unsigned WIDTH     = 2,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic                   clk_sig,
   input logic                   reset_sig,
   serial2parallel_framed_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] asm_q;
   logic [WIDTH-1:0] asm_next;
   logic [CNT_W-1:0] idx;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [CNT_W-1:0] out_nbits_q;
   logic             out_last_q;
   logic             ready;
   logic             accept;
   logic             drain;
   logic             complete;

   // Ready depends only on the output slot, so the source never sees a loop through in_valid.
   assign ready    = !out_valid_q || bus.out_ready;
   assign accept   = bus.in_valid && ready;
   assign drain    = out_valid_q && bus.out_ready;
   assign complete = accept && ((cnt == CNT_W'(WIDTH - 1)) || bus.in_last);
   assign idx      = MSB_FIRST ? (CNT_W'(WIDTH - 1) - cnt) : cnt;

   always_comb begin
      asm_next = asm_q;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (accept && (idx == CNT_W'(i))) begin
            asm_next[i] = bus.serial_sig;
         end
      end
   end

   always_ff @(posedge clk_sig) begin
      if (reset_sig) begin
         cnt         <= '0;
         asm_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_nbits_q <= '0;
         out_last_q  <= 1'b0;
      end else if (complete) begin
         // A completing bit is only accepted when the slot is free or draining this edge.
         out_data_q  <= asm_next;
         out_nbits_q <= cnt + CNT_W'(1);
         out_last_q  <= bus.in_last;
         out_valid_q <= 1'b1;
         cnt         <= '0;
         asm_q       <= '0;
      end else begin
         if (accept) begin
            cnt   <= cnt + CNT_W'(1);
            asm_q <= asm_next;
         end
         if (drain) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_nbits = out_nbits_q;
   assign bus.out_last  = out_last_q;
endmodule
